// File: rtl/ps2_keymap_ext.sv
// PS/2 set-2 scan-code parser with plain and E0-extended key maps and an edge-only event stream.
// Define PS2_KEYMAP_EVENT_FIFO_EN to buffer events in a FWFT FIFO; otherwise events are one-cycle pulses.
module ps2_keymap_ext #(
    parameter int unsigned  FIFO_DEPTH = 8,
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          PS2scan_ready,
    input  logic [7:0]    PS2scan_code,
    input  logic          Clear,
    output logic [127:0]  KeyMap,
    output logic [127:0]  KeyMapExt,
    output logic          Ev_valid,
    output logic [9:0]    Ev_data,
    input  logic          Ev_pop,
    output logic [CW-1:0] Ev_count,
    output logic          Ev_overflow
);

    typedef enum logic [2:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0, ST_PAUSE} state_t;

    state_t     state, state_nx;
    logic [2:0] skip, skip_nx;
    logic       key_c, brk_c, ext_c, pause_c, cur_c, push_c;
    logic [6:0] idx_c;
    logic [9:0] ev_data_c;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            skip  <= 3'd0;
        end else if (Clear) begin
            state <= ST_IDLE;
            skip  <= 3'd0;
        end else begin
            state <= state_nx;
            skip  <= skip_nx;
        end
    end

    // Prefix tracking; the pause sequence swallows 7 bytes after E1 regardless of content.
    always_comb begin
        state_nx = state;
        skip_nx  = skip;
        key_c    = 1'b0;
        brk_c    = 1'b0;
        ext_c    = 1'b0;
        pause_c  = 1'b0;
        if (PS2scan_ready) begin
            if (state == ST_PAUSE) begin
                if (skip <= 3'd1) begin
                    state_nx = ST_IDLE;
                    skip_nx  = 3'd0;
                    pause_c  = 1'b1;
                end else begin
                    skip_nx = skip - 3'd1;
                end
            end else if (PS2scan_code == 8'hE0) begin
                state_nx = ST_E0;
            end else if (PS2scan_code == 8'hE1) begin
                state_nx = ST_PAUSE;
                skip_nx  = 3'd7;
            end else if (PS2scan_code == 8'hF0) begin
                state_nx = (state == ST_E0) ? ST_E0F0 : ST_F0;
            end else begin
                state_nx = ST_IDLE;
                key_c    = ~PS2scan_code[7];
                brk_c    = (state == ST_F0) || (state == ST_E0F0);
                ext_c    = (state == ST_E0) || (state == ST_E0F0);
            end
        end
    end

    assign idx_c     = PS2scan_code[6:0];
    assign cur_c     = ext_c ? KeyMapExt[idx_c] : KeyMap[idx_c];
    // A make only matters if the key was up, a break only if it was down.
    assign push_c    = (key_c && (brk_c == cur_c)) || pause_c;
    assign ev_data_c = pause_c ? 10'h1E1 : {brk_c, ext_c, PS2scan_code};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            KeyMap    <= '0;
            KeyMapExt <= '0;
        end else if (Clear) begin
            KeyMap    <= '0;
            KeyMapExt <= '0;
        end else if (key_c) begin
            if (ext_c) KeyMapExt[idx_c] <= ~brk_c;
            else       KeyMap[idx_c]    <= ~brk_c;
        end
    end

`ifdef PS2_KEYMAP_EVENT_FIFO_EN
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          pop_c, full_c, wr_c;

    assign pop_c  = Ev_pop && (count != '0);
    assign full_c = (count == CW'(FIFO_DEPTH));
    assign wr_c   = push_c && (!full_c || pop_c);

    always_ff @(posedge Clock) begin
        if (wr_c && !Clear) mem[wr_ptr] <= ev_data_c;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (Clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(wr_c);
            rd_ptr   <= rd_ptr + AW'(pop_c);
            if (wr_c && !pop_c)      count <= count + CW'(1);
            else if (!wr_c && pop_c) count <= count - CW'(1);
            if (push_c && full_c && !pop_c) overflow <= 1'b1;
        end
    end

    assign Ev_valid    = (count != '0);
    assign Ev_data     = Ev_valid ? mem[rd_ptr] : 10'd0;
    assign Ev_count    = count;
    assign Ev_overflow = overflow;
`else
    logic unused_pop;
    assign unused_pop = Ev_pop;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Ev_valid <= 1'b0;
            Ev_data  <= 10'd0;
        end else if (Clear) begin
            Ev_valid <= 1'b0;
        end else begin
            Ev_valid <= push_c;
            if (push_c) Ev_data <= ev_data_c;
        end
    end

    assign Ev_count    = '0;
    assign Ev_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keymap_ext.sv
// Directed bench for ps2_keymap_ext; covers both the FIFO and pulse event builds.
module tb_ps2_keymap_ext;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          PS2scan_ready = 1'b0;
    logic [7:0]    PS2scan_code = 8'h00;
    logic          Clear = 1'b0;
    logic [127:0]  KeyMap, KeyMapExt;
    logic          Ev_valid;
    logic [9:0]    Ev_data;
    logic          Ev_pop = 1'b0;
    logic [CW-1:0] Ev_count;
    logic          Ev_overflow;

    int checks = 0;
    int errors = 0;
    logic [9:0] evq[$];
    logic [9:0] expq[$];

    ps2_keymap_ext #(.FIFO_DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .PS2scan_ready(PS2scan_ready),
        .PS2scan_code(PS2scan_code), .Clear(Clear), .KeyMap(KeyMap),
        .KeyMapExt(KeyMapExt), .Ev_valid(Ev_valid), .Ev_data(Ev_data),
        .Ev_pop(Ev_pop), .Ev_count(Ev_count), .Ev_overflow(Ev_overflow)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

`ifndef PS2_KEYMAP_EVENT_FIFO_EN
    // Pulse build: collect every event strobe.
    always @(negedge Clock) if (Ev_valid) evq.push_back(Ev_data);
`endif

    task automatic send(input logic [7:0] b);
        @(negedge Clock);
        PS2scan_ready = 1'b1;
        PS2scan_code  = b;
        @(negedge Clock);
        PS2scan_ready = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        @(negedge Clock);
        evq.delete();
    endtask

    task automatic drain();
`ifdef PS2_KEYMAP_EVENT_FIFO_EN
        for (int i = 0; i < 70 && Ev_valid; i++) begin
            evq.push_back(Ev_data);
            Ev_pop = 1'b1;
            @(negedge Clock);
            Ev_pop = 1'b0;
        end
        check("drain_bound", 128'(Ev_valid), 128'(0));
`else
        @(negedge Clock);
`endif
    endtask

    task automatic compare_events(input string tag);
        drain();
        check({tag, "_n"}, 128'(evq.size()), 128'(expq.size()));
        for (int i = 0; i < expq.size() && i < evq.size(); i++)
            check($sformatf("%s_ev%0d", tag, i), 128'(evq[i]), 128'(expq[i]));
        evq.delete();
        expq.delete();
    endtask

    function automatic logic [127:0] bit_at(input logic [6:0] i);
        logic [127:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_map", KeyMap, 128'(0));
        check("rst_mapext", KeyMapExt, 128'(0));
        check("rst_valid", 128'(Ev_valid), 128'(0));
        check("rst_data", 128'(Ev_data), 128'(0));
        check("rst_count", 128'(Ev_count), 128'(0));
        check("rst_ovf", 128'(Ev_overflow), 128'(0));

        // make then break of 1C
        send(8'h1C);
        check("mk1c_map", KeyMap, bit_at(7'h1C));
`ifdef PS2_KEYMAP_EVENT_FIFO_EN
        check("mk1c_count", 128'(Ev_count), 128'(1));
        check("mk1c_valid", 128'(Ev_valid), 128'(1));
        check("mk1c_head", 128'(Ev_data), 128'(10'h01C));
`endif
        send(8'hF0); send(8'h1C);
        check("br1c_map", KeyMap, 128'(0));
        expq.push_back(10'h01C); expq.push_back(10'h21C);
        compare_events("seq1c");

        // extended 75 make and break
        send(8'hE0); send(8'h75);
        check("mk75_ext", KeyMapExt, bit_at(7'h75));
        check("mk75_map", KeyMap, 128'(0));
        send(8'hE0); send(8'hF0); send(8'h75);
        check("br75_ext", KeyMapExt, 128'(0));
        check("br75_map", KeyMap, 128'(0));
        expq.push_back(10'h175); expq.push_back(10'h375);
        compare_events("seq75");

        // typematic repeat
        do_clear();
        send(8'h1C); send(8'h1C); send(8'h1C);
`ifdef PS2_KEYMAP_EVENT_FIFO_EN
        check("rpt_count", 128'(Ev_count), 128'(1));
`else
        check("rpt_count", 128'(Ev_count), 128'(0));
`endif
        expq.push_back(10'h01C);
        compare_events("rpt");

        // pause sequence
        do_clear();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_map", KeyMap, 128'(0));
        check("pause_ext", KeyMapExt, 128'(0));
        expq.push_back(10'h1E1);
        compare_events("pause");
        send(8'h1C);
        check("post_pause_map", KeyMap, bit_at(7'h1C));

        // ignored bytes and restart from a prefix
        do_clear();
        send(8'hAA); send(8'hFA);
        check("ign_map", KeyMap, 128'(0));
        send(8'hE0); send(8'hAA); send(8'h1C);
        check("e0aa_map", KeyMap, bit_at(7'h1C));
        check("e0aa_ext", KeyMapExt, 128'(0));
        send(8'hF0); send(8'hE0); send(8'h75);
        check("restart_ext", KeyMapExt, bit_at(7'h75));
        check("restart_map", KeyMap, bit_at(7'h1C));
        expq.push_back(10'h01C); expq.push_back(10'h175);
        compare_events("ign");

        // Clear beats a same-cycle strobe
        do_clear();
        @(negedge Clock);
        PS2scan_ready = 1'b1; PS2scan_code = 8'h1C; Clear = 1'b1;
        @(negedge Clock);
        PS2scan_ready = 1'b0; Clear = 1'b0;
        check("clrpri_map", KeyMap, 128'(0));
        check("clrpri_count", 128'(Ev_count), 128'(0));
        compare_events("clrpri");

        // Reset mid-sequence
        send(8'hE0);
        @(negedge Clock); Reset = 1'b1;
        @(negedge Clock); Reset = 1'b0;
        evq.delete();
        send(8'h1C);
        check("rstmid_map", KeyMap, bit_at(7'h1C));
        check("rstmid_ext", KeyMapExt, 128'(0));

        // overflow and full push+pop
        do_clear();
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
`ifdef PS2_KEYMAP_EVENT_FIFO_EN
        check("ovf_count", 128'(Ev_count), 128'(4));
        check("ovf_flag", 128'(Ev_overflow), 128'(1));
        check("ovf_head", 128'(Ev_data), 128'(10'h015));
`endif
        @(negedge Clock);
        PS2scan_ready = 1'b1; PS2scan_code = 8'h35; Ev_pop = 1'b1;
        @(negedge Clock);
        PS2scan_ready = 1'b0; Ev_pop = 1'b0;
`ifdef PS2_KEYMAP_EVENT_FIFO_EN
        check("pp_count", 128'(Ev_count), 128'(4));
        check("pp_head", 128'(Ev_data), 128'(10'h01D));
        check("pp_flag", 128'(Ev_overflow), 128'(1));
        expq.push_back(10'h01D); expq.push_back(10'h024);
        expq.push_back(10'h02D); expq.push_back(10'h035);
`else
        check("pp_count", 128'(Ev_count), 128'(0));
        check("pp_flag", 128'(Ev_overflow), 128'(0));
        expq.push_back(10'h015); expq.push_back(10'h01D); expq.push_back(10'h024);
        expq.push_back(10'h02D); expq.push_back(10'h02C); expq.push_back(10'h035);
`endif
        compare_events("ovf");

        // pop on empty is ignored; Clear drops the sticky flag
        @(negedge Clock); Ev_pop = 1'b1;
        @(negedge Clock); Ev_pop = 1'b0;
        check("emptypop_count", 128'(Ev_count), 128'(0));
        check("emptypop_valid", 128'(Ev_valid), 128'(0));
        do_clear();
        check("clr_ovf", 128'(Ev_overflow), 128'(0));
        check("clr_map", KeyMap, 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_keymap_ext.md
PS2_KEYMAP_EXT -- requirements
Module: ps2_keymap_ext

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth; legal values are powers of 2 from 2 to 64.
REQ-002 SHALL have localparam CW = log2(FIFO_DEPTH)+1, the width of the FIFO occupancy count.
REQ-003 SHALL have port Clock, input, 1 bit: system clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port PS2scan_ready, input, 1 bit: one-cycle strobe qualifying PS2scan_code.
REQ-006 SHALL have port PS2scan_code, input, 8 bits: received scan-code byte (set 2).
REQ-007 SHALL have port Clear, input, 1 bit: synchronous clear of maps, parser, FIFO and overflow flag.
REQ-008 SHALL have port KeyMap, output, 128 bits: pressed state of non-prefixed keys, indexed by code[6:0].
REQ-009 SHALL have port KeyMapExt, output, 128 bits: pressed state of E0-prefixed keys, indexed by code[6:0].
REQ-010 SHALL have port Ev_valid, output, 1 bit: event available at the FIFO head.
REQ-011 SHALL have port Ev_data, output, 10 bits: {break, ext, code[7:0]}.
REQ-012 SHALL have port Ev_pop, input, 1 bit: consumer acknowledge; pops the head when Ev_valid=1.
REQ-013 SHALL have port Ev_count, output, CW bits: FIFO occupancy.
REQ-014 SHALL have port Ev_overflow, output, 1 bit: sticky flag, set when an event is dropped.

Function
REQ-015 Parser states: IDLE, E0, F0, E0F0, PAUSE; only bytes with PS2scan_ready=1 are consumed.
REQ-016 IDLE transitions: byte E0 -> E0; byte F0 -> F0; byte E1 -> PAUSE with skip counter=7.
REQ-017 In IDLE, any other byte < 0x80 is a make on KeyMap; the state stays IDLE.
REQ-018 E0 transitions: F0 -> E0F0; byte < 0x80 -> make on KeyMapExt, then IDLE.
REQ-019 F0 -> break on KeyMap; E0F0 -> break on KeyMapExt; both then return to IDLE.
REQ-020 Bytes 0x80-0xFF other than the prefixes (e.g. AA, FA, FE, EE) SHALL be ignored and force IDLE with no map change; an unexpected E0 or E1 inside a sequence restarts parsing from that byte.
REQ-021 PAUSE: each byte decrements the counter; at 0 push event {0,1,8'hE1}, no map change, return to IDLE.
REQ-022 A make sets and a break clears map bit code[6:0], visible the cycle after the completing byte's strobe.
REQ-023 An event SHALL be pushed only when the map bit changes, so typematic repeats and breaks of released keys produce no event.
REQ-024 The FIFO SHALL be first-word-fall-through; Ev_valid and Ev_data reflect a push on the next cycle; Ev_count increments the same cycle.
REQ-025 Simultaneous push and pop SHALL both be accepted, including when the FIFO is full, leaving Ev_count unchanged.
REQ-026 A push when full without pop SHALL be dropped, set Ev_overflow, and leave FIFO contents unchanged.
REQ-027 Ev_pop with Ev_valid=0 SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-028 Clear SHALL take priority over a same-cycle strobe or pop.

Reset
REQ-029 On Reset: KeyMap=0, KeyMapExt=0, parser=IDLE, skip counter=0, FIFO empty, Ev_valid=0, Ev_data=0, Ev_count=0, Ev_overflow=0.
REQ-030 Reset mid-sequence (e.g. after E0 or inside PAUSE) SHALL discard partial state; the first byte after release is parsed from IDLE.

Configuration
REQ-031 Macro PS2_KEYMAP_EVENT_FIFO_EN defined: FIFO per REQ-024..027.
REQ-032 Macro PS2_KEYMAP_EVENT_FIFO_EN undefined: no storage; Ev_valid is a one-cycle registered pulse with Ev_data per event; Ev_pop ignored; Ev_count=0; Ev_overflow=0; maps identical.

Verification
REQ-033 Strobe 1C, then F0 1C -> KeyMap[0x1C] 1 then 0; events 0x01C and 0x21C in order.
REQ-034 Strobe E0 75, E0 F0 75 -> KeyMapExt[0x75] toggles, KeyMap unchanged; events 0x175 and 0x375.
REQ-035 Strobe 1C three times -> exactly one event, Ev_count=1.
REQ-036 Strobe E1 14 77 E1 F0 14 F0 77 -> single event 0x1E1; KeyMap[0x14] and KeyMap[0x77] stay 0.
REQ-037 FIFO_DEPTH=4, 5 distinct makes, no pop -> Ev_count=4, Ev_overflow=1, head 1st key; push+pop when full keeps Ev_count=4.
REQ-038 Strobe E0, assert Reset, then strobe 1C -> KeyMap[0x1C]=1, KeyMapExt=0.
